gpu_cmd_queue: RTL

//  Upstream feeder for the GPU command port. Buffers CPU-side (cmd, data) writes in a FIFO.

---
 rtl/gpu_cmd_queue.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/gpu_cmd_queue.sv
// CPU-side command FIFO replayed to the GPU command port as setup/strobe/hold transactions.
// Optional GPU_CMD_VSYNC_SWAP_EN: adds vblank_in and holds display commands until vertical blank.
module gpu_cmd_queue #(
  parameter int DEPTH         = 16,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [1:0]               wr_cmd,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     overflow,
  output logic [1:0]               cmd_out,
  output logic [7:0]               data_out,
  output logic                     strobe_out
`ifdef GPU_CMD_VSYNC_SWAP_EN
  ,
  input  logic                     vblank_in
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 8;
  localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_overflow;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_strobe;
  logic [1:0]    r_cmd;
  logic [7:0]    r_data;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_head_ok;
  logic [9:0]    w_head;

  assign w_full  = (r_level == (AW+1)'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rd_ptr];

`ifdef GPU_CMD_VSYNC_SWAP_EN
  // Display commands wait at the head for vblank; everything behind them waits too.
  assign w_head_ok = (w_head[9:8] != 2'b10) || vblank_in;
`else
  assign w_head_ok = 1'b1;
`endif

  assign w_push = wr_en && !w_full;
  assign w_pop  = (r_state == S_IDLE) && !w_empty && w_head_ok;

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= {wr_cmd, wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      if (wr_en && w_full) r_overflow <= 1'b1;
    end
  end

  // Single down-counter, reloaded on every state change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_strobe <= 1'b0;
      r_cmd    <= '0;
      r_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cmd   <= w_head[9:8];
            r_data  <= w_head[7:0];
            r_state <= S_SETUP;
            r_cnt   <= SETUP_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_state  <= S_STROBE;
            r_strobe <= 1'b1;
            r_cnt    <= STROBE_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STROBE: begin
          if (r_cnt == '0) begin
            r_state  <= S_HOLD;
            r_strobe <= 1'b0;
            r_cnt    <= HOLD_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign full       = w_full;
  assign empty      = w_empty;
  assign level      = r_level;
  assign busy       = r_busy;
  assign overflow   = r_overflow;
  assign cmd_out    = r_cmd;
  assign data_out   = r_data;
  assign strobe_out = r_strobe;

endmodule
